// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch and IF/ID register; FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    fetch_stage_if.master       imem,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic [31:0]         instr_o,
    output logic [6:0]          op_o,
    output logic [XLEN-1:0]     pc_o,
    output logic [XLEN-1:0]     pc_plus4_o,
    output logic                instr_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt_o,
    output logic [31:0]         stall_cnt_o
`endif
);
    typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e          state_q;
    logic            req_valid_q, discard_q, valid_q, valid_d;
    logic [XLEN-1:0] fetch_pc_q, pc_q, pc_d, hold_pc_q;
    logic [31:0]     instr_q, instr_d, hold_instr_q;
    logic            rsp, kill, load_rsp, load_hold;
    logic [XLEN-1:0] redir_pc;

    assign rsp       = state_q == S_WAIT && imem.rsp_valid;
    assign kill      = flush_i | redirect_i;
    assign load_rsp  = rsp && !discard_q && !kill && !stall_i;
    assign load_hold = state_q == S_HOLD && !kill && !stall_i;
    assign redir_pc  = redirect_pc_i & ~XLEN'(3);

    always_comb begin
        instr_d = kill ? NOP_INSTR : load_rsp ? imem.rsp_data : load_hold ? hold_instr_q : instr_q;
        pc_d    = kill ? pc_q : load_rsp ? fetch_pc_q : load_hold ? hold_pc_q : pc_q;
        valid_d = kill ? 1'b0 : (load_rsp || load_hold) ? 1'b1 : valid_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_RST;
            req_valid_q  <= 1'b0;
            discard_q    <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= RESET_PC;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            case (state_q)
                S_RST: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end
                S_REQ: if (imem.req_ready) begin
                    state_q     <= S_WAIT;
                    req_valid_q <= 1'b0;
                    discard_q   <= redirect_i;
                end
                S_WAIT: if (imem.rsp_valid) begin
                    // a redirect coinciding with the response simply drops that stale word
                    if (discard_q || redirect_i) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        discard_q   <= 1'b0;
                    end else begin
                        fetch_pc_q <= fetch_pc_q + XLEN'(4);
                        if (stall_i || flush_i) begin
                            state_q      <= S_HOLD;
                            hold_instr_q <= imem.rsp_data;
                            hold_pc_q    <= fetch_pc_q;
                        end else begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end else if (redirect_i) begin
                    discard_q <= 1'b1;
                end
                S_HOLD: if (redirect_i || load_hold) begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end
            endcase
            if (redirect_i) fetch_pc_q <= redir_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(load_rsp || load_hold);
            stall_cnt_q <= stall_cnt_q + 32'(stall_i && valid_q);
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

    assign imem.req_valid = req_valid_q;
    assign imem.addr      = fetch_pc_q;
    assign instr_o        = instr_q;
    assign op_o           = instr_q[6:0];
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_q + XLEN'(4);
    assign instr_valid_o  = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed fetch_stage bench against a queue-based fetch model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, redirect;
    logic [31:0] rpc, instr, pc, pc4;
    logic [6:0]  op;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt, scnt;
`endif

    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .imem(bus),
        .stall_i(stall), .flush_i(flush), .redirect_i(redirect), .redirect_pc_i(rpc),
        .instr_o(instr), .op_o(op), .pc_o(pc), .pc_plus4_o(pc4), .instr_valid_o(valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(fcnt), .stall_cnt_o(scnt)
`endif
    );

    int total = 0, bad = 0;
    int mode = 1;                  // 0 random memory, 1 zero-wait, 2 never respond
    logic [31:0] pend[$];          // addresses accepted by memory, awaiting response
    logic [63:0] m_buf[$];         // words fetched but not yet handed to decode
    bit          m_start, m_iss, m_inf, m_drop, m_v;
    logic [31:0] m_pc, m_ins, m_ipc, m_fc, m_sc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a == 32'h0 ? 32'h0000_0093 : a == 32'h4 ? 32'h0010_0113 : (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic step(input bit rn, input bit st, input bit fl, input bit rdi, input logic [31:0] tgt);
        bit rdy, rv, kill, resp, keep, from_rsp, from_buf, had_buf;
        logic [31:0] rd;
        rdy = mode == 0 ? 1'($urandom % 2) : 1'b1;
        if (pend.size() > 0) begin
            rv = mode == 1 ? 1'b1 : mode == 0 ? ($urandom % 3 == 0) : 1'b0;
            rd = memword(pend[0]);
        end else begin
            rv = mode == 0 && ($urandom % 8 == 0);
            rd = $urandom;
        end
        rst_n = rn; stall = st; flush = fl; redirect = rdi; rpc = tgt;
        bus.req_ready = rdy; bus.rsp_valid = rv; bus.rsp_data = rd;
        @(posedge clk);
        if (!rn) begin
            m_start = 1; m_iss = 0; m_inf = 0; m_drop = 0; m_v = 0;
            m_pc = 0; m_ins = 32'h13; m_ipc = 0; m_fc = 0; m_sc = 0;
            m_buf.delete(); pend.delete();
        end else begin
            kill     = fl || rdi;
            resp     = m_inf && rv;
            keep     = resp && !m_drop && !rdi;
            from_rsp = keep && !st && !fl;
            had_buf  = m_buf.size() > 0;
            from_buf = had_buf && !st && !kill;
            m_fc += 32'(from_rsp || from_buf);
            m_sc += 32'(st && m_v);
            if (kill) begin m_ins = 32'h13; m_v = 0; end
            else if (from_rsp) begin m_ins = rd; m_ipc = m_pc; m_v = 1; end
            else if (from_buf) begin m_ins = m_buf[0][63:32]; m_ipc = m_buf[0][31:0]; m_v = 1; end
            if (rdi || from_buf) m_buf.delete();
            else if (keep && !from_rsp) m_buf.push_back({rd, m_pc});
            if (rv && pend.size() > 0) void'(pend.pop_front());
            if (m_start) begin
                m_start = 0; m_iss = 1;
            end else if (m_iss) begin
                if (rdy) begin m_iss = 0; m_inf = 1; m_drop = rdi; pend.push_back(m_pc); end
            end else if (m_inf) begin
                if (resp) begin m_inf = 0; m_drop = 0; m_iss = !(keep && !from_rsp); end
                else if (rdi) m_drop = 1;
            end else if (had_buf && (rdi || from_buf)) begin
                m_iss = 1;
            end
            if (rdi) m_pc = tgt & ~32'h3;
            else if (keep) m_pc = m_pc + 32'h4;
        end
        @(negedge clk);
        check("req_valid", 32'(bus.req_valid), 32'(m_iss));
        check("addr", bus.addr, m_pc);
        check("instr", instr, m_ins);
        check("op", 32'(op), 32'(m_ins[6:0]));
        check("pc", pc, m_ipc);
        check("pc_plus4", pc4, m_ipc + 32'h4);
        check("valid", 32'(valid), 32'(m_v));
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", fcnt, m_fc);
        check("stall_cnt", scnt, m_sc);
`endif
    endtask

    initial begin
        logic [31:0] prev;
        rst_n = 0; stall = 0; flush = 0; redirect = 0; rpc = 0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_data = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_instr", instr, 32'h13);
        check("rst_op", 32'(op), 32'h13);
        check("rst_req", 32'(bus.req_valid), 0);
        check("rst_pc4", pc4, 32'h4);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("first_instr", instr, 32'h0000_0093);
        check("first_pc", pc, 32'h0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("second_instr", instr, 32'h0010_0113);
        check("second_pc", pc, 32'h4);
        check("second_op", 32'(op), 32'h13);
        prev = instr;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            check("stall_hold", instr, prev);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && !m_inf; i++) step(1, 0, 0, 0, 0);
        mode = 2;
        step(1, 0, 0, 1, 32'h0000_0103);
        check("redir_instr", instr, 32'h13);
        check("redir_valid", 32'(valid), 0);
        mode = 1;
        step(1, 0, 0, 0, 0);
        check("redir_gap_valid", 32'(valid), 0);
        check("redir_req", 32'(bus.req_valid), 1);
        check("redir_addr", bus.addr, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("flush_stall_instr", instr, 32'h13);
        check("flush_stall_valid", 32'(valid), 0);
        step(1, 0, 0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && !(m_v && m_ipc == 32'hFFFF_FFFC); i++) step(1, 0, 0, 0, 0);
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        check("wrap_addr", bus.addr, 32'h0);
        mode = 2;
        for (int i = 0; i < 10 && !m_inf; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("midrst_instr", instr, 32'h13);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_addr", bus.addr, 32'h0);
        check("midrst_req", 32'(bus.req_valid), 0);
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] t;
            t = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            step($urandom % 300 != 0, $urandom % 4 == 0, $urandom % 12 == 0, $urandom % 15 == 0, t);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
